fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_if.sv | 55 +++++
 rtl/fetch_decode.sv | 249 ++++++++++++++++++++++++
 tb/tb_fetch_decode.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - instruction-fetch and decode-output bundle for fetch_decode
//
// Purpose: groups the instruction-memory handshake, the decoded-instruction
// outputs toward the reservation-station stage and the downstream
// backpressure/redirect inputs.
// Optional: FD_ILLEGAL_EN adds the 1-bit illegal flag.
//
// Ports (master = fetch_decode side):
//   imem_req, imem_addr[31:0]     out  fetch request pulse and word address
//   imem_rdata[31:0], imem_valid  in   fetched word and its valid strobe
//   dec_valid                     out  decoded instruction present
//   opcode, rd, fun3, rs1, rs2,
//   fun7, imm[31:0], opc[31:0]    out  decoded fields and instruction PC
//   illegal                       out  unknown opcode (FD_ILLEGAL_EN only)
//   is_busy                       in   downstream stall, decode outputs hold
//   get_npc, npc[31:0]            in   redirect strobe and target PC
interface fetch_decode_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        dec_valid;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  fun3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  fun7;
   logic [31:0] imm;
   logic [31:0] opc;
`ifdef FD_ILLEGAL_EN
   logic        illegal;
`endif
   logic        is_busy;
   logic        get_npc;
   logic [31:0] npc;

   modport master (
`ifdef FD_ILLEGAL_EN
      output illegal,
`endif
      output imem_req, imem_addr, dec_valid, opcode, rd, fun3, rs1, rs2,
             fun7, imm, opc,
      input  imem_rdata, imem_valid, is_busy, get_npc, npc
   );

   modport slave (
`ifdef FD_ILLEGAL_EN
      input  illegal,
`endif
      input  imem_req, imem_addr, dec_valid, opcode, rd, fun3, rs1, rs2,
             fun7, imm, opc,
      output imem_rdata, imem_valid, is_busy, get_npc, npc
   );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - single-outstanding instruction fetch with RV32 field decode
//
// Purpose: issues one instruction-memory fetch at a time, decodes the
// returned word into register/immediate fields, presents them until the
// downstream stage accepts, and follows redirects from downstream.
// Optional: FD_ILLEGAL_EN flags unknown opcodes with illegal=1 and zeroed
// fields; without it unknown opcodes pass raw fields with imm=0.
//
// Ports:
//   clk     in   sole clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bus     fetch_decode_if.master (imem handshake, decode outputs,
//           is_busy backpressure, get_npc/npc redirect)
// Parameter:
//   RESET_PC  first fetch address after reset (word aligned)
module fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_decode_if.master bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  fun3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  fun7;
      logic [31:0] imm;
   } dec_t;

   // Field extraction plus per-format immediate assembly and zeroing of
   // fields that the format does not carry.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d.opcode = w[6:0];
      d.rd     = w[11:7];
      d.fun3   = w[14:12];
      d.rs1    = w[19:15];
      d.rs2    = w[24:20];
      d.fun7   = w[31:25];
      d.imm    = '0;
      case (w[6:0])
         OP_LOAD, OP_JALR: begin
            d.imm  = {{20{w[31]}}, w[31:20]};
            d.rs2  = '0;
            d.fun7 = '0;
         end
         OP_IMM: begin
            d.imm = {{20{w[31]}}, w[31:20]};
            d.rs2 = '0;
            // shift-immediates carry the arithmetic/logical selector in fun7
            if (!(w[14:12] == 3'b001 || w[14:12] == 3'b101)) begin
               d.fun7 = '0;
            end
         end
         OP_STORE: begin
            d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            d.rd  = '0;
         end
         OP_BRANCH: begin
            d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            d.rd  = '0;
         end
         OP_LUI, OP_AUIPC: begin
            d.imm  = {w[31:12], 12'b0};
            d.rs1  = '0;
            d.rs2  = '0;
            d.fun7 = '0;
         end
         OP_JAL: begin
            d.imm  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            d.rs1  = '0;
            d.rs2  = '0;
            d.fun7 = '0;
         end
         OP_OP: begin
            d.imm = '0;
         end
         default: begin
`ifdef FD_ILLEGAL_EN
            d = '0;
`else
            d.imm = '0;
`endif
         end
      endcase
      return d;
   endfunction

`ifdef FD_ILLEGAL_EN
   function automatic logic known_opcode(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_OP,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction
`endif

   state_t      state_q,     state_d;
   logic [31:0] pc_q,        pc_d;
   logic        discard_q,   discard_d;
   logic        imem_req_q,  imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        dec_valid_q, dec_valid_d;
   dec_t        dec_q,       dec_d;
   logic [31:0] opc_q,       opc_d;
`ifdef FD_ILLEGAL_EN
   logic        illegal_q,   illegal_d;
`endif

   // Redirect targets are forced word aligned.
   logic [31:0] npc_aligned;
   assign npc_aligned = bus.npc & 32'hFFFF_FFFC;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      discard_d   = discard_q;
      imem_req_d  = 1'b0;
      imem_addr_d = imem_addr_q;
      // decode outputs fall to zero unless explicitly loaded or held
      dec_valid_d = 1'b0;
      dec_d       = '0;
      opc_d       = '0;
`ifdef FD_ILLEGAL_EN
      illegal_d   = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            if (bus.get_npc) begin
               // no request goes out on a redirect cycle, so nothing is
               // left outstanding against the old PC
               pc_d = npc_aligned;
            end else begin
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_valid) begin
               if (bus.get_npc || discard_q) begin
                  // stale response: drop it and refetch from the redirect PC
                  if (bus.get_npc) begin
                     pc_d = npc_aligned;
                  end
                  discard_d = 1'b0;
                  state_d   = S_FETCH;
               end else begin
                  dec_valid_d = 1'b1;
                  dec_d       = decode(bus.imem_rdata);
                  opc_d       = pc_q;
                  pc_d        = pc_q + 32'd4;
                  state_d     = S_HOLD;
`ifdef FD_ILLEGAL_EN
                  illegal_d   = !known_opcode(bus.imem_rdata[6:0]);
`endif
               end
            end else if (bus.get_npc) begin
               // response still in flight; later redirects just retarget pc
               pc_d      = npc_aligned;
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.get_npc) begin
               pc_d    = npc_aligned;
               state_d = S_FETCH;
            end else if (bus.is_busy) begin
               dec_valid_d = dec_valid_q;
               dec_d       = dec_q;
               opc_d       = opc_q;
`ifdef FD_ILLEGAL_EN
               illegal_d   = illegal_q;
`endif
            end else begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         discard_q   <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
         dec_valid_q <= 1'b0;
         dec_q       <= '0;
         opc_q       <= '0;
`ifdef FD_ILLEGAL_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         discard_q   <= discard_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         dec_valid_q <= dec_valid_d;
         dec_q       <= dec_d;
         opc_q       <= opc_d;
`ifdef FD_ILLEGAL_EN
         illegal_q   <= illegal_d;
`endif
      end
   end

   assign bus.imem_req  = imem_req_q;
   assign bus.imem_addr = imem_addr_q;
   assign bus.dec_valid = dec_valid_q;
   assign bus.opcode    = dec_q.opcode;
   assign bus.rd        = dec_q.rd;
   assign bus.fun3      = dec_q.fun3;
   assign bus.rs1       = dec_q.rs1;
   assign bus.rs2       = dec_q.rs2;
   assign bus.fun7      = dec_q.fun7;
   assign bus.imm       = dec_q.imm;
   assign bus.opc       = opc_q;
`ifdef FD_ILLEGAL_EN
   assign bus.illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - self-checking bench for fetch_decode
module tb_fetch_decode;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_decode_if bus();

   fetch_decode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;

   typedef struct {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  fun3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  fun7;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   // Reference decode from the format rules using plain integer arithmetic.
   function automatic exp_t model(input logic [31:0] w);
      exp_t        e;
      int unsigned u;
      int          s;
      u = w;
      s = $signed(w);
      e.opcode = 7'(u % 128);
      e.rd     = 5'((u >> 7) % 32);
      e.fun3   = 3'((u >> 12) % 8);
      e.rs1    = 5'((u >> 15) % 32);
      e.rs2    = 5'((u >> 20) % 32);
      e.fun7   = 7'(u >> 25);
      e.imm    = 32'd0;
      e.ill    = 1'b0;
      case (int'(e.opcode))
         3, 19, 103: begin
            e.imm = 32'(s >>> 20);
            e.rs2 = 5'd0;
            if (!(e.opcode == 7'd19 && (e.fun3 == 3'd1 || e.fun3 == 3'd5))) e.fun7 = 7'd0;
         end
         35: begin
            e.imm = 32'((s >>> 25) * 32 + int'((u >> 7) % 32));
            e.rd  = 5'd0;
         end
         99: begin
            e.imm = 32'((s < 0 ? -4096 : 0) + int'((u >> 7) % 2) * 2048
                        + int'((u >> 25) % 64) * 32 + int'((u >> 8) % 16) * 2);
            e.rd  = 5'd0;
         end
         55, 23: begin
            e.imm  = 32'(u - (u % 4096));
            e.rs1  = 5'd0;
            e.rs2  = 5'd0;
            e.fun7 = 7'd0;
         end
         111: begin
            e.imm  = 32'((s < 0 ? -(1 << 20) : 0) + int'((u >> 12) % 256) * 4096
                         + int'((u >> 20) % 2) * 2048 + int'((u >> 21) % 1024) * 2);
            e.rs1  = 5'd0;
            e.rs2  = 5'd0;
            e.fun7 = 7'd0;
         end
         51: ;
         default: begin
`ifdef FD_ILLEGAL_EN
            e.opcode = 7'd0; e.rd = 5'd0; e.fun3 = 3'd0; e.rs1 = 5'd0;
            e.rs2 = 5'd0; e.fun7 = 7'd0; e.ill = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dec(input exp_t e, input logic [31:0] pc);
      chk("dec_valid", 32'(bus.dec_valid), 32'd1);
      chk("opcode", 32'(bus.opcode), 32'(e.opcode));
      chk("rd", 32'(bus.rd), 32'(e.rd));
      chk("fun3", 32'(bus.fun3), 32'(e.fun3));
      chk("rs1", 32'(bus.rs1), 32'(e.rs1));
      chk("rs2", 32'(bus.rs2), 32'(e.rs2));
      chk("fun7", 32'(bus.fun7), 32'(e.fun7));
      chk("imm", bus.imm, e.imm);
      chk("opc", bus.opc, pc);
`ifdef FD_ILLEGAL_EN
      chk("illegal", 32'(bus.illegal), 32'(e.ill));
`endif
   endtask

   task automatic check_idle();
      chk("idle_dec_valid", 32'(bus.dec_valid), 32'd0);
      chk("idle_fields", {bus.opcode, bus.rd, bus.fun3, bus.rs1, bus.rs2, bus.fun7}, 32'd0);
      chk("idle_imm", bus.imm, 32'd0);
      chk("idle_opc", bus.opc, 32'd0);
`ifdef FD_ILLEGAL_EN
      chk("idle_illegal", 32'(bus.illegal), 32'd0);
`endif
   endtask

   // Request must appear on the very next edge, at the expected PC.
   task automatic wait_req();
      int d = 0;
      do begin
         @(negedge clk);
         d++;
      end while (!bus.imem_req && d < 8);
      chk("req_latency", 32'(d), 32'd1);
      chk("req_addr", bus.imem_addr, exp_pc);
   endtask

   task automatic fetch_one(input logic [31:0] word, input int lat, input int busy);
      exp_t e;
      e = model(word);
      wait_req();
      for (int k = 0; k < lat; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("no_req_in_wait", 32'(bus.imem_req), 32'd0);
         chk("no_dec_in_wait", 32'(bus.dec_valid), 32'd0);
      end
      @(posedge clk); #1;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = word;
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      bus.is_busy    = (busy > 0);
      @(negedge clk);
      check_dec(e, exp_pc);
      for (int k = 0; k < busy; k++) begin
         @(negedge clk);
         check_dec(e, exp_pc);
         chk("no_req_in_hold", 32'(bus.imem_req), 32'd0);
      end
      bus.is_busy = 1'b0;
      @(negedge clk);
      check_idle();
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic redirect_wait(input logic [31:0] n1, input logic [31:0] n2, input bit two);
      wait_req();
      @(posedge clk); #1;
      bus.get_npc = 1'b1;
      bus.npc     = n1;
      @(posedge clk); #1;
      if (two) begin
         bus.npc = n2;
         @(posedge clk); #1;
      end
      bus.get_npc = 1'b0;
      @(negedge clk);
      chk("no_req_discard", 32'(bus.imem_req), 32'd0);
      chk("no_dec_discard", 32'(bus.dec_valid), 32'd0);
      @(posedge clk); #1;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'h00500093;
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      @(negedge clk);
      chk("dropped_dec_valid", 32'(bus.dec_valid), 32'd0);
      exp_pc = (two ? n2 : n1) & 32'hFFFF_FFFC;
   endtask

   task automatic redirect_same(input logic [31:0] n);
      wait_req();
      @(posedge clk); #1;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'h00A00113;
      bus.get_npc    = 1'b1;
      bus.npc        = n;
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      bus.get_npc    = 1'b0;
      @(negedge clk);
      chk("same_cycle_dec_valid", 32'(bus.dec_valid), 32'd0);
      exp_pc = n & 32'hFFFF_FFFC;
   endtask

   task automatic redirect_hold(input logic [31:0] word, input logic [31:0] n);
      exp_t e;
      e = model(word);
      wait_req();
      @(posedge clk); #1;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = word;
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      bus.get_npc    = 1'b1;
      bus.npc        = n;
      bus.is_busy    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_dec(e, exp_pc);
      @(posedge clk); #1;
      bus.get_npc = 1'b0;
      bus.is_busy = 1'b0;
      @(negedge clk);
      check_idle();
      exp_pc = n & 32'hFFFF_FFFC;
   endtask

   // Called at the negedge after an acceptance, i.e. while the FSM sits in FETCH.
   task automatic redirect_fetch(input logic [31:0] n);
      bus.get_npc = 1'b1;
      bus.npc     = n;
      @(negedge clk);
      chk("no_req_on_redirect", 32'(bus.imem_req), 32'd0);
      bus.get_npc = 1'b0;
      exp_pc = n & 32'hFFFF_FFFC;
   endtask

   function automatic logic [31:0] rand_word();
      logic [6:0]  ops [10];
      logic [31:0] w;
      ops = '{7'd3, 7'd35, 7'd99, 7'd19, 7'd51, 7'd55, 7'd23, 7'd111, 7'd103, 7'd0};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.is_busy    = 1'b0;
      bus.get_npc    = 1'b0;
      bus.npc        = 32'd0;
      exp_pc         = 32'd0;

      // reset state
      #12;
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'd0);
      check_idle();
      @(negedge clk);
      rst_n = 1'b1;

      // addi x1,x0,5 with a 4-cycle stall, then refetch at 4
      fetch_one(32'h00500093, 0, 4);
      // branch immediate, then assorted formats and latencies
      fetch_one(32'hFE000EE3, 1, 0);
      fetch_one(32'hFE112E23, 0, 1);   // sw
      fetch_one(32'h123450B7, 2, 0);   // lui
      fetch_one(32'hFF9FF0EF, 0, 2);   // jal negative
      fetch_one(32'h40315093, 1, 0);   // srai keeps fun7
      fetch_one(32'h00C58533, 0, 0);   // add
      fetch_one(32'hFFC28067, 0, 1);   // jalr
      fetch_one(32'hFFFFF017, 0, 0);   // auipc
      fetch_one(32'hFFFFFFFF, 1, 1);   // unknown opcode

      // redirects
      redirect_wait(32'h0000_0041, 32'd0, 1'b0);
      fetch_one(32'h00A00113, 0, 0);
      redirect_wait(32'h0000_0200, 32'h0000_0302, 1'b1);
      fetch_one(32'h00802183, 0, 0);   // lw
      redirect_same(32'h0000_0080);
      fetch_one(32'h00000463, 0, 0);   // beq +8
      redirect_hold(32'h00100093, 32'h0000_0500);
      fetch_one(32'h00000013, 0, 0);
      redirect_fetch(32'hFFFF_FFFF);   // pc wraps after this fetch
      fetch_one(32'h7FF00093, 0, 0);
      fetch_one(32'h800000B7, 0, 0);

      // asynchronous reset while an instruction is held
      begin
         exp_t e;
         e = model(32'h00300193);
         wait_req();
         @(posedge clk); #1;
         bus.imem_valid = 1'b1;
         bus.imem_rdata = 32'h00300193;
         @(posedge clk); #1;
         bus.imem_valid = 1'b0;
         bus.is_busy    = 1'b1;
         @(negedge clk);
         check_dec(e, exp_pc);
         #2 rst_n = 1'b0;
         #1;
         chk("arst_imem_req", 32'(bus.imem_req), 32'd0);
         chk("arst_imem_addr", bus.imem_addr, 32'd0);
         check_idle();
         bus.is_busy = 1'b0;
         @(negedge clk);
         rst_n  = 1'b1;
         exp_pc = 32'd0;
      end

      // randomized fetch stream
      for (int i = 0; i < 24; i++) begin
         fetch_one(rand_word(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
